// File: rtl/vexbus_dmem_responder_if.sv
// VexRiscv simple data bus: cmd channel (core -> memory) and rsp channel
// (memory -> core). The rsp channel has no ready; responses are single-cycle.
interface vexbus_dmem_responder_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_wr;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_data;
   logic [1:0]  cmd_size;
   logic        rsp_valid;
   logic        rsp_error;
   logic [31:0] rsp_data;

   modport master (
      output cmd_valid, cmd_wr, cmd_addr, cmd_data, cmd_size,
      input  cmd_ready, rsp_valid, rsp_error, rsp_data
   );

   modport slave (
      input  cmd_valid, cmd_wr, cmd_addr, cmd_data, cmd_size,
      output cmd_ready, rsp_valid, rsp_error, rsp_data
   );
endinterface

// File: rtl/vexbus_dmem_responder.sv
// Data-bus responder: byte-writable word RAM, fixed read latency, optional
// LFSR-driven backpressure and saturating activity counters.
module vexbus_dmem_responder #(
   parameter int          AW        = 12,
   parameter logic [31:0] BASE      = 32'h0000_0000,
   parameter int          LATENCY   = 1,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                   CLK,
   input  logic                   RST,
   vexbus_dmem_responder_if.slave bus,
   input  logic                   stall_en,
   output logic [15:0]            n_rd,
   output logic [15:0]            n_wr,
   output logic [15:0]            n_err
);
   localparam int DEPTH = 1 << AW;
   localparam int DW    = 32 * LATENCY;

   logic [15:0]            r_lfsr;
   logic [LATENCY:1]       r_vld_pipe;
   logic [LATENCY:1]       r_err_pipe;
   logic [LATENCY:1][31:0] r_dat_pipe;
   logic [15:0]            r_n_rd;
   logic [15:0]            r_n_wr;
   logic [15:0]            r_n_err;

   logic          w_ready;
   logic          w_acc;
   logic          w_oor;
   logic          w_misal;
   logic          w_err;
   logic          w_wr_ok;
   logic          w_rd;
   logic [3:0]    w_mask;
   logic [AW-1:0] w_idx;
   logic [31:0]   w_rdata;
   logic [31:0]   w_dat0;

   // Ready depends only on registered state, never on cmd_valid.
   assign w_ready = stall_en ? r_lfsr[0] : 1'b1;
   // Commands presented while in reset are ignored even though ready may be 1.
   assign w_acc   = bus.cmd_valid & w_ready & ~RST;
   assign w_oor   = bus.cmd_addr[31:AW+2] != BASE[31:AW+2];
   assign w_err   = w_oor | w_misal;
   assign w_idx   = bus.cmd_addr[AW+1:2];
   assign w_wr_ok = w_acc & bus.cmd_wr & ~w_err;
   assign w_rd    = w_acc & ~bus.cmd_wr;
   // Erroring reads carry zero data so rsp_data stays clean.
   assign w_dat0  = (w_rd & ~w_err) ? w_rdata : 32'h0;

   // Size decode: alignment legality and byte-lane write mask.
   always_comb begin
      w_misal = 1'b0;
      w_mask  = 4'b0000;
      case (bus.cmd_size)
         2'b00: w_mask = 4'b0001 << bus.cmd_addr[1:0];
         2'b01: begin
            w_mask  = 4'b0011 << bus.cmd_addr[1:0];
            w_misal = bus.cmd_addr[0];
         end
         2'b10: begin
            w_mask  = 4'b1111;
            w_misal = bus.cmd_addr[1:0] != 2'b00;
         end
         default: w_misal = 1'b1;
      endcase
   end

   // RAM is split into four byte banks so each lane has its own write enable.
   // Not reset: contents survive RST.
   for (genvar g = 0; g < 4; g++) begin : g_lane
      logic [7:0] r_bank [DEPTH];

      // Lane write when the command is a legal accepted write covering this byte.
      always_ff @(posedge CLK) begin
         if (w_wr_ok & w_mask[g]) r_bank[w_idx] <= bus.cmd_data[8*g +: 8];
      end

      assign w_rdata[8*g +: 8] = r_bank[w_idx];
   end

   // Read pipeline: stage 1 captures the RAM word at the accept edge, the rest only delay it.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_vld_pipe <= '0;
         r_err_pipe <= '0;
         r_dat_pipe <= '0;
      end else begin
         r_vld_pipe <= LATENCY'({r_vld_pipe, w_rd});
         r_err_pipe <= LATENCY'({r_err_pipe, w_rd & w_err});
         r_dat_pipe <= DW'({r_dat_pipe, w_dat0});
      end
   end

   // Free-running Fibonacci LFSR, x^16+x^14+x^13+x^11+1.
   always_ff @(posedge CLK) begin
      if (RST) r_lfsr <= LFSR_SEED;
      else     r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
   end

   // Saturating activity counters; errors count once regardless of direction.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_n_rd  <= '0;
         r_n_wr  <= '0;
         r_n_err <= '0;
      end else begin
         if (w_rd & ~w_err & (r_n_rd != 16'hFFFF))   r_n_rd  <= r_n_rd + 16'd1;
         if (w_wr_ok & (r_n_wr != 16'hFFFF))         r_n_wr  <= r_n_wr + 16'd1;
         if (w_acc & w_err & (r_n_err != 16'hFFFF))  r_n_err <= r_n_err + 16'd1;
      end
   end

   assign bus.cmd_ready = w_ready;
   assign bus.rsp_valid = r_vld_pipe[LATENCY];
   assign bus.rsp_error = r_err_pipe[LATENCY];
   assign bus.rsp_data  = r_dat_pipe[LATENCY];
   assign n_rd          = r_n_rd;
   assign n_wr          = r_n_wr;
   assign n_err         = r_n_err;
endmodule

// File: tb/tb_vexbus_dmem_responder.sv
// Bench for vexbus_dmem_responder: two instances (LATENCY 1 and 4) share one
// stimulus stream; a byte-level memory model predicts responses and counters.
module tb_vexbus_dmem_responder;
   localparam int          AW   = 6;
   localparam int          NB   = 4 << AW;
   localparam int          NW   = 1 << AW;
   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam logic [15:0] SEED = 16'hACE1;

   logic        CLK       = 1'b0;
   logic        RST       = 1'b1;
   logic        stall_en  = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_wr    = 1'b0;
   logic [31:0] cmd_addr  = '0;
   logic [31:0] cmd_data  = '0;
   logic [1:0]  cmd_size  = '0;
   logic [15:0] n_rd1, n_wr1, n_err1, n_rd4, n_wr4, n_err4;

   always #5 CLK = ~CLK;

   vexbus_dmem_responder_if bus1 ();
   vexbus_dmem_responder_if bus4 ();
   assign bus1.cmd_valid = cmd_valid;
   assign bus1.cmd_wr    = cmd_wr;
   assign bus1.cmd_addr  = cmd_addr;
   assign bus1.cmd_data  = cmd_data;
   assign bus1.cmd_size  = cmd_size;
   assign bus4.cmd_valid = cmd_valid;
   assign bus4.cmd_wr    = cmd_wr;
   assign bus4.cmd_addr  = cmd_addr;
   assign bus4.cmd_data  = cmd_data;
   assign bus4.cmd_size  = cmd_size;

   vexbus_dmem_responder #(.AW(AW), .BASE(BASE), .LATENCY(1), .LFSR_SEED(SEED)) u_dut1 (
      .CLK(CLK), .RST(RST), .bus(bus1), .stall_en(stall_en),
      .n_rd(n_rd1), .n_wr(n_wr1), .n_err(n_err1));
   vexbus_dmem_responder #(.AW(AW), .BASE(BASE), .LATENCY(4), .LFSR_SEED(SEED)) u_dut4 (
      .CLK(CLK), .RST(RST), .bus(bus4), .stall_en(stall_en),
      .n_rd(n_rd4), .n_wr(n_wr4), .n_err(n_err4));

   typedef struct { int due; logic err; logic [31:0] data; } exp_t;
   typedef struct { int cyc; logic err; logic [31:0] data; } rec_t;

   exp_t        q1[$], q4[$];
   rec_t        rec1[$], rec4[$];
   logic [7:0]  m_mem [NB];
   logic [15:0] m_lfsr, m_nrd, m_nwr, m_nerr;
   int          cyc = 0, m_rdacc = 0, checks = 0, failures = 0;
   bit          mon_en = 1'b0;

   function automatic logic [15:0] sat(input logic [15:0] x);
      return (x == 16'hFFFF) ? x : x + 16'd1;
   endfunction

   function automatic logic bad_access(input logic [31:0] a, input logic [1:0] sz);
      if (a < BASE || a >= BASE + NB) return 1'b1;
      case (sz)
         2'd0:    return 1'b0;
         2'd1:    return (a % 2) != 0;
         2'd2:    return (a % 4) != 0;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] word_at(input int off);
      int o = off & ~3;
      return {m_mem[o+3], m_mem[o+2], m_mem[o+1], m_mem[o]};
   endfunction

   function automatic logic exp_ready();
      return stall_en ? m_lfsr[0] : 1'b1;
   endfunction

   // Reference model, evaluated at every rising edge with the sampled inputs.
   initial begin
      logic       rdy, e;
      int         off, lo;
      logic [31:0] d;
      forever begin
         @(posedge CLK);
         cyc++;
         if (RST) begin
            m_lfsr = SEED;
            m_nrd = '0; m_nwr = '0; m_nerr = '0;
            q1.delete(); q4.delete();
         end else begin
            rdy = exp_ready();
            if (cmd_valid && rdy) begin
               e   = bad_access(cmd_addr, cmd_size);
               off = int'(cmd_addr - BASE);
               lo  = int'(cmd_addr[1:0]);
               if (e) m_nerr = sat(m_nerr);
               if (cmd_wr) begin
                  if (!e) begin
                     for (int b = 0; b < (1 << cmd_size); b++)
                        m_mem[off + b] = cmd_data[8*(lo + b) +: 8];
                     m_nwr = sat(m_nwr);
                  end
               end else begin
                  m_rdacc++;
                  if (!e) m_nrd = sat(m_nrd);
                  d = e ? 32'h0 : word_at(off);
                  q1.push_back('{due: cyc, err: e, data: d});
                  q4.push_back('{due: cyc + 3, err: e, data: d});
               end
            end
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
         end
      end
   end

   // Records every response and compares outputs against the model each cycle.
   initial begin
      exp_t       x;
      logic       ev, ee;
      logic [31:0] ed;
      forever begin
         @(negedge CLK);
         if (bus1.rsp_valid === 1'b1) rec1.push_back('{cyc: cyc, err: bus1.rsp_error, data: bus1.rsp_data});
         if (bus4.rsp_valid === 1'b1) rec4.push_back('{cyc: cyc, err: bus4.rsp_error, data: bus4.rsp_data});
         if (mon_en) begin
            ev = 1'b0; ee = 1'b0; ed = 32'h0;
            if (q1.size() > 0 && q1[0].due == cyc) begin
               x = q1.pop_front(); ev = 1'b1; ee = x.err; ed = x.data;
            end
            checks++;
            if ({bus1.rsp_valid, bus1.rsp_error, bus1.rsp_data} !== {ev, ee, ed}) begin
               failures++;
               $display("FAIL mon_rsp_lat1 cyc=%0d got v=%b e=%b d=%h need v=%b e=%b d=%h",
                        cyc, bus1.rsp_valid, bus1.rsp_error, bus1.rsp_data, ev, ee, ed);
            end
            ev = 1'b0; ee = 1'b0; ed = 32'h0;
            if (q4.size() > 0 && q4[0].due == cyc) begin
               x = q4.pop_front(); ev = 1'b1; ee = x.err; ed = x.data;
            end
            checks++;
            if ({bus4.rsp_valid, bus4.rsp_error, bus4.rsp_data} !== {ev, ee, ed}) begin
               failures++;
               $display("FAIL mon_rsp_lat4 cyc=%0d got v=%b e=%b d=%h need v=%b e=%b d=%h",
                        cyc, bus4.rsp_valid, bus4.rsp_error, bus4.rsp_data, ev, ee, ed);
            end
            checks++;
            if ({bus1.cmd_ready, bus4.cmd_ready} !== {2{exp_ready()}}) begin
               failures++;
               $display("FAIL mon_ready cyc=%0d got %b%b need %b", cyc, bus1.cmd_ready,
                        bus4.cmd_ready, exp_ready());
            end
            checks++;
            if ({n_rd1, n_wr1, n_err1, n_rd4, n_wr4, n_err4} !== {2{m_nrd, m_nwr, m_nerr}}) begin
               failures++;
               $display("FAIL mon_counters cyc=%0d got %0d/%0d/%0d %0d/%0d/%0d need %0d/%0d/%0d",
                        cyc, n_rd1, n_wr1, n_err1, n_rd4, n_wr4, n_err4, m_nrd, m_nwr, m_nerr);
            end
         end
      end
   end

   task automatic drive(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
      cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_data = d; cmd_size = sz;
   endtask

   // Presents a command and returns the edge index at which it was accepted.
   task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, output int acc);
      drive(wr, a, d, sz);
      acc = -1;
      for (int i = 0; i < 200; i++) begin
         logic r;
         r = exp_ready();
         @(posedge CLK); #1;
         if (r) begin acc = cyc; break; end
      end
      if (acc < 0) begin
         checks++; failures++;
         $display("FAIL issue_timeout addr=%h got no accept need accept within 200 cycles", a);
      end
   endtask

   task automatic idle(input int n);
      cmd_valid = 1'b0;
      repeat (n) begin @(posedge CLK); #1; end
   endtask

   task automatic test_reset();
      logic [15:0] s;
      s = SEED;
      RST = 1'b1; stall_en = 1'b0; cmd_valid = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      checks++;
      if ({bus1.rsp_valid, bus1.rsp_error, bus1.rsp_data} !== 34'h0) begin
         failures++; $display("FAIL rst_rsp_lat1 got %b/%b/%h need 0/0/0", bus1.rsp_valid, bus1.rsp_error, bus1.rsp_data);
      end
      checks++;
      if ({bus4.rsp_valid, bus4.rsp_error, bus4.rsp_data} !== 34'h0) begin
         failures++; $display("FAIL rst_rsp_lat4 got %b/%b/%h need 0/0/0", bus4.rsp_valid, bus4.rsp_error, bus4.rsp_data);
      end
      checks++;
      if ({n_rd1, n_wr1, n_err1, n_rd4, n_wr4, n_err4} !== 96'h0) begin
         failures++; $display("FAIL rst_counters got %0d/%0d/%0d %0d/%0d/%0d need 0", n_rd1, n_wr1, n_err1, n_rd4, n_wr4, n_err4);
      end
      checks++;
      if ({bus1.cmd_ready, bus4.cmd_ready} !== 2'b11) begin
         failures++; $display("FAIL rst_ready got %b%b need 11", bus1.cmd_ready, bus4.cmd_ready);
      end
      stall_en = 1'b1; #1;
      checks++;
      if ({bus1.cmd_ready, bus4.cmd_ready} !== {2{s[0]}}) begin
         failures++; $display("FAIL rst_ready_stall got %b%b need %b", bus1.cmd_ready, bus4.cmd_ready, s[0]);
      end
      stall_en = 1'b0; RST = 1'b0;
      @(posedge CLK); #1;
      mon_en = 1'b1;
   endtask

   task automatic test_word_rw();
      int aw, ar;
      rec1.delete(); rec4.delete();
      issue(1'b1, BASE + 32'h10, 32'h1122_3344, 2'd2, aw);
      issue(1'b0, BASE + 32'h10, 32'h0, 2'd2, ar);
      idle(6);
      checks++;
      if (rec1.size() != 1 || rec1[0].cyc != ar || rec1[0].data !== 32'h1122_3344 || rec1[0].err !== 1'b0) begin
         failures++; $display("FAIL word_rw_lat1 got n=%0d cyc=%0d d=%h need n=1 cyc=%0d d=11223344",
                              rec1.size(), rec1.size() ? rec1[0].cyc : -1, rec1.size() ? rec1[0].data : 32'h0, ar);
      end
      checks++;
      if (rec4.size() != 1 || rec4[0].cyc != ar + 3 || rec4[0].data !== 32'h1122_3344 || rec4[0].err !== 1'b0) begin
         failures++; $display("FAIL word_rw_lat4 got n=%0d cyc=%0d d=%h need n=1 cyc=%0d d=11223344",
                              rec4.size(), rec4.size() ? rec4[0].cyc : -1, rec4.size() ? rec4[0].data : 32'h0, ar + 3);
      end
      checks++;
      if ({n_wr1, n_rd1, n_wr4, n_rd4} !== {4{16'd1}}) begin
         failures++; $display("FAIL word_rw_counters got wr=%0d rd=%0d wr=%0d rd=%0d need 1", n_wr1, n_rd1, n_wr4, n_rd4);
      end
   endtask

   task automatic test_byte_half();
      int a;
      issue(1'b1, BASE + 32'h13, 32'hAAAA_AAAA, 2'd0, a);
      issue(1'b1, BASE + 32'h10, 32'hBBBB_BBBB, 2'd1, a);
      rec1.delete(); rec4.delete();
      issue(1'b0, BASE + 32'h10, 32'h0, 2'd2, a);
      idle(6);
      checks++;
      if (rec1.size() != 1 || rec1[0].data !== 32'hAA22_BBBB || rec4.size() != 1 || rec4[0].data !== 32'hAA22_BBBB) begin
         failures++; $display("FAIL byte_half got n=%0d/%0d d=%h/%h need AA22BBBB", rec1.size(), rec4.size(),
                              rec1.size() ? rec1[0].data : 32'h0, rec4.size() ? rec4[0].data : 32'h0);
      end
   endtask

   task automatic test_fill();
      int a;
      for (int w = 0; w < NW; w++)
         if (w != 4) issue(1'b1, BASE + 32'(4 * w), $urandom, 2'd2, a);
      idle(1);
   endtask

   task automatic test_back_to_back();
      int a[4];
      rec1.delete(); rec4.delete();
      for (int i = 0; i < 4; i++) issue(1'b0, BASE + 32'(4 * i), 32'h0, 2'd2, a[i]);
      idle(6);
      checks++;
      if (rec1.size() != 4 || rec4.size() != 4) begin
         failures++; $display("FAIL b2b_count got %0d/%0d need 4/4", rec1.size(), rec4.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (rec1[i].cyc != a[0] + i || rec1[i].data !== word_at(4 * i) ||
                rec4[i].cyc != a[0] + 3 + i || rec4[i].data !== word_at(4 * i)) begin
               failures++; $display("FAIL b2b_rsp%0d got cyc=%0d/%0d d=%h/%h need cyc=%0d/%0d d=%h", i,
                                    rec1[i].cyc, rec4[i].cyc, rec1[i].data, rec4[i].data, a[0] + i, a[0] + 3 + i, word_at(4 * i));
            end
         end
      end
   endtask

   task automatic test_errors();
      int a;
      logic [31:0] w0;
      w0 = word_at(0);
      rec1.delete(); rec4.delete();
      issue(1'b0, BASE + 32'h21, 32'h0, 2'd1, a);
      idle(5);
      checks++;
      if (rec1.size() != 1 || rec4.size() != 1 || {rec1[0].err, rec1[0].data, rec4[0].err, rec4[0].data} !== {1'b1, 32'h0, 1'b1, 32'h0}) begin
         failures++; $display("FAIL err_half_read got n=%0d/%0d need one error response of data 0 each", rec1.size(), rec4.size());
      end
      checks++;
      if (n_err1 !== 16'd1 || n_err4 !== 16'd1) begin
         failures++; $display("FAIL err_count1 got %0d/%0d need 1", n_err1, n_err4);
      end
      issue(1'b1, BASE + 32'(NB), $urandom, 2'd2, a);
      idle(5);
      checks++;
      if (n_err1 !== 16'd2 || n_err4 !== 16'd2 || rec1.size() != 1 || rec4.size() != 1) begin
         failures++; $display("FAIL err_oor_write got err=%0d/%0d n=%0d/%0d need err=2 n=1", n_err1, n_err4, rec1.size(), rec4.size());
      end
      rec1.delete(); rec4.delete();
      issue(1'b0, BASE, 32'h0, 2'd2, a);
      idle(6);
      checks++;
      if (rec1.size() != 1 || rec4.size() != 1 || rec1[0].data !== w0 || rec4[0].data !== w0) begin
         failures++; $display("FAIL err_word0_kept got n=%0d/%0d need d=%h", rec1.size(), rec4.size(), w0);
      end
   endtask

   task automatic test_random();
      int          start;
      logic [1:0]  sz;
      logic [31:0] a;
      rec1.delete(); rec4.delete();
      start = m_rdacc;
      for (int i = 0; i < 400; i++) begin
         if (i % 16 == 0) stall_en = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 7))
            0:       a = BASE + 32'(NB) + 32'($urandom_range(0, NB - 1));
            1:       a = BASE - 32'd4;
            default: a = BASE + 32'($urandom_range(0, NB - 1));
         endcase
         if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
         drive(1'($urandom_range(0, 1)), a, $urandom, sz);
         cmd_valid = ($urandom_range(0, 3) != 0);
         @(posedge CLK); #1;
      end
      idle(6);
      stall_en = 1'b0;
      checks++;
      if (rec1.size() != m_rdacc - start || rec4.size() != m_rdacc - start) begin
         failures++; $display("FAIL random_rsp_count got %0d/%0d need %0d", rec1.size(), rec4.size(), m_rdacc - start);
      end
   endtask

   task automatic test_stall();
      int nacc = 0;
      stall_en = 1'b1; cmd_valid = 1'b0; RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      checks++;
      if (bus1.cmd_ready !== 1'b1 || bus4.cmd_ready !== 1'b1) begin
         failures++; $display("FAIL stall_first_ready got %b/%b need 1", bus1.cmd_ready, bus4.cmd_ready);
      end
      rec1.delete(); rec4.delete();
      for (int i = 0; i < 64; i++) begin
         drive(1'b0, BASE + 32'(4 * $urandom_range(0, NW - 1)), 32'h0, 2'd2);
         if (exp_ready()) nacc++;
         @(posedge CLK); #1;
      end
      idle(6);
      stall_en = 1'b0;
      checks++;
      if (rec1.size() != nacc || rec4.size() != nacc || n_rd1 !== 16'(nacc) || n_rd4 !== 16'(nacc)) begin
         failures++; $display("FAIL stall_accepts got rsp=%0d/%0d n_rd=%0d/%0d need %0d", rec1.size(), rec4.size(), n_rd1, n_rd4, nacc);
      end
   endtask

   task automatic test_reset_inflight();
      int a, wa;
      logic [31:0] ea;
      stall_en = 1'b0;
      wa = $urandom_range(0, NW - 2);
      ea = word_at(4 * wa);
      issue(1'b0, BASE + 32'(4 * wa), 32'h0, 2'd2, a);
      issue(1'b0, BASE + 32'(4 * wa + 4), 32'h0, 2'd2, a);
      cmd_valid = 1'b0; RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      rec1.delete(); rec4.delete();
      checks++;
      if ({n_rd1, n_wr1, n_err1, n_rd4, n_wr4, n_err4} !== 96'h0) begin
         failures++; $display("FAIL inflight_counters got %0d/%0d/%0d %0d/%0d/%0d need 0", n_rd1, n_wr1, n_err1, n_rd4, n_wr4, n_err4);
      end
      idle(8);
      checks++;
      if (rec1.size() != 0 || rec4.size() != 0) begin
         failures++; $display("FAIL inflight_dropped got %0d/%0d responses need 0", rec1.size(), rec4.size());
      end
      issue(1'b0, BASE + 32'(4 * wa), 32'h0, 2'd2, a);
      idle(6);
      checks++;
      if (rec1.size() != 1 || rec4.size() != 1 || rec1[0].data !== ea || rec4[0].data !== ea) begin
         failures++; $display("FAIL inflight_ram_kept got n=%0d/%0d need d=%h", rec1.size(), rec4.size(), ea);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got no completion need finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_word_rw();
      test_byte_half();
      test_fill();
      test_back_to_back();
      test_errors();
      test_random();
      test_stall();
      test_reset_inflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/vexbus_dmem_responder.md
# vexbus_dmem_responder

Responder (slave) end of the VexRiscv simple data bus: it accepts `cmd` transactions from the core's dBus, serves them from an internal byte-writable word RAM with a fixed, parameterised read latency, and returns read data on the `rsp` channel. An optional LFSR-driven stall mode deasserts `cmd_ready` pseudo-randomly to exercise core backpressure handling. Saturating counters expose read, write and error activity. The block sits between the core wrapper and the SoC memory map, replacing the ideal always-ready memory model.

## Interface
- `AW`, 12: log2 of RAM depth in 32-bit words (RAM = 4·2^AW bytes).
- `BASE`, 32'h0000_0000: byte base address; aligned to 4·2^AW.
- `LATENCY`, 1: read latency in cycles from accept to `rsp_valid`; legal 1..4.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.

- `CLK` in 1: the single clock; all state changes on its rising edge.
- `RST` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: responder can accept this cycle.
- `cmd_wr` in 1: 1 = write, 0 = read.
- `cmd_addr` in 32: byte address.
- `cmd_data` in 32: write data; the core has already replicated it across lanes.
- `cmd_size` in 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `stall_en` in 1: 1 = `cmd_ready` follows the LFSR.
- `rsp_valid` out 1: read response present (single cycle; no ready on this channel).
- `rsp_error` out 1: the response is for an erroring read.
- `rsp_data` out 32: raw RAM word; the core performs lane extraction.
- `n_rd`, `n_wr`, `n_err` out 16 each: saturating counters.

## Operation
- Accept: `acc = cmd_valid & cmd_ready`. Only accepted commands have any effect.
- `cmd_ready`:
  - 1 when `stall_en=0`; `lfsr[0]` when `stall_en=1`.
  - It never depends combinationally on `cmd_valid`.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Shifts every cycle regardless of `stall_en`: `lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}`.
- Error detection (any one condition flags the access):
  - out of range: `cmd_addr[31:AW+2] != BASE[31:AW+2]`;
  - `cmd_size=11`;
  - `cmd_size=01` with `addr[0]=1`;
  - `cmd_size=10` with `addr[1:0]!=0`.
- Byte mask:
  - size 00 → `4'b0001<<addr[1:0]`;
  - size 01 → `4'b0011<<addr[1:0]`;
  - size 10 → `4'b1111`.
- Accepted write, no error: each masked byte lane of RAM word `addr[AW+1:2]` is written from the same lane of `cmd_data`; `n_wr` increments. No response is produced.
- Accepted write, error: RAM is unchanged, `n_err` increments, no response.
- Accepted read:
  - The access enters a LATENCY-stage pipeline carrying valid, error and data.
  - RAM is read in the accept cycle's edge; extra stages only delay the result.
  - No error: `n_rd` increments.
  - Error: `n_err` increments; the response carries `rsp_error=1` and `rsp_data=0`.
- Pipeline accepts one command per cycle. Responses come out in order and can be back-to-back.
- A read accepted the cycle after a write to the same word returns the new data; write-first ordering is by cycle.
- Counters saturate at 16'hFFFF.

## Timing
- Reset (`RST=1` at an edge):
  - pipeline valids cleared, so in-flight reads are dropped and never answered;
  - counters set to 0; `lfsr` set to `LFSR_SEED`;
  - RAM contents retained.
  - Outputs after reset: `rsp_valid=0`, `rsp_error=0`, `rsp_data=0`, counters 0. `cmd_ready` = 1, or `LFSR_SEED[0]` when `stall_en=1`.
- While `RST=1`, `cmd_ready` stays at its formula value, but commands are ignored (no RAM write, no counter change, nothing enters the pipeline).
- Read accepted at edge k → `rsp_valid=1` during the cycle after edge k+LATENCY−1. LATENCY=1 gives the response in the next cycle.
- `rsp_data` and `rsp_error` are 0 whenever `rsp_valid=0`.
- All outputs except `cmd_ready` are registered.

## Test plan
- Write word 0x11223344 to BASE+0x10, then read it (LATENCY=1 and 4) → `rsp_valid` exactly LATENCY cycles after the read accept, data 0x11223344, `n_wr=1`, `n_rd=1`.
- Byte write `cmd_data`=0xAAAAAAAA at BASE+0x13 size 00, then half write 0xBBBBBBBB at BASE+0x10 size 01, then word read → 0xAA22BBBB.
- Four reads to BASE+0x0/4/8/C in consecutive cycles → four consecutive `rsp_valid` cycles, data in order, no gaps.
- Half read at BASE+0x21 → `rsp_error=1`, `rsp_data=0`, `n_err=1`. Word write to BASE+(4<<AW) → no response, word 0 unchanged, `n_err=2`.
- `stall_en=1`, `cmd_valid` held high for 64 cycles with reads → accepts occur only in cycles where `cmd_ready=lfsr[0]`; first cycle ready=1 (seed 0xACE1); response count equals accept count.
- Two reads in flight (LATENCY=4), `RST` pulsed for one cycle → no `rsp_valid` afterwards, counters 0; a later read returns the pre-reset RAM data.
